// File: rtl/alu_cmd_queue.sv
// ---------------------------------------------------------------------------
// alu_cmd_queue
//
// First-word-fall-through command queue that sits directly in front of the
// registered ALU stage. The operator-input logic pushes (function, data)
// pairs. The ALU stage consumes the head entry through a valid/ready
// handshake. Entries leave in push order. There is no bypass path, so a pushed
// entry becomes visible one edge after it is written.
//
// Optional feature:
//   ALU_CMD_QUEUE_OVERFLOW_STICKY_EN
//     When defined, o_overflow is a sticky flag. It sets at the edge where a
//     push is dropped because the queue is full and no pop occurs. Only
//     i_rst clears it.
//     When undefined, o_overflow is tied to 0 and dropped pushes are silent.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   DATA_W  operand width
//   FUNC_W  function-select width
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            asynchronous active-high reset
//   i_push           write request for i_push_data / i_push_function
//   i_push_data      operand to enqueue
//   i_push_function  function select to enqueue
//   o_full           queue holds DEPTH entries
//   o_valid          head entry present on o_data / o_function
//   i_ready          ALU stage accepts the head entry this cycle
//   o_data           head operand (0 when o_valid = 0)
//   o_function       head function (0 when o_valid = 0)
//   o_count          number of entries currently stored
//   o_overflow       sticky push-while-full flag (0 when the feature is off)
// ---------------------------------------------------------------------------
module alu_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int FUNC_W = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic [FUNC_W-1:0]          i_push_function,
  output logic                       o_full,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [FUNC_W-1:0]          o_function,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = FUNC_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Storage is not reset. Valid gating of the outputs hides stale contents.
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push_acc;
  logic [DEPTH-1:0] w_wr_en;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0] w_count_next;

  // Flags are decoded from the registered count only. They never depend on
  // this cycle's inputs.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == DEPTH_CNT);

  // A pop needs a present head. A ready signal while the queue is empty is
  // ignored.
  assign w_pop = w_valid & i_ready;

  // A push while full is accepted only if the head leaves in the same cycle.
  // That pop frees the slot the write pointer is about to reuse.
  assign w_push_acc = i_push & (~w_full | w_pop);

  // Per-entry write enables decoded from the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign w_wr_en[gi] = w_push_acc & (r_wr_ptr == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_en[i]) begin
        r_mem[i] <= {i_push_function, i_push_data};
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push_acc, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // DEPTH is a power of two, so natural pointer rollover is the modulo wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

`ifdef ALU_CMD_QUEUE_OVERFLOW_STICKY_EN
  logic r_overflow;

  // Sets only when a push is actually dropped. A push while full that is
  // paired with a pop is a legal replace, not an overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (i_push & w_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  // Combinational head read. Forcing the outputs to zero while empty keeps
  // uninitialised storage off the ALU inputs. During reset, the zero count
  // gates the outputs immediately.
  assign w_head     = r_mem[r_rd_ptr];
  assign o_data     = w_valid ? w_head[DATA_W-1:0] : '0;
  assign o_function = w_valid ? w_head[ENTRY_W-1:DATA_W] : '0;

  assign o_valid = w_valid;
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule
